// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports; a grant is decided in IDLE and the request is issued the next cycle.
// The request is held until mem_ack_i, which is forwarded the same cycle; waiting ports see combinational stalls.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_ack_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   input  logic [3:0]  dm_be_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_ack_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic        stall_if_o,
   output logic        stall_dm_o
);

   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   state_t            state_q,     state_d;
   logic [CNT_W-1:0]  streak_q,    streak_d;
   logic              mem_req_q,   mem_req_d;
   logic              mem_we_q,    mem_we_d;
   logic [31:0]       mem_addr_q,  mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q,    mem_be_d;
   logic [31:0]       if_rdata_q,  if_rdata_d;
   logic [31:0]       dm_rdata_q,  dm_rdata_d;
   logic              if_ack,      dm_ack;

   assign if_ack = (state_q == GNT_IF) & mem_ack_i;
   assign dm_ack = (state_q == GNT_DM) & mem_ack_i;

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (!if_req_i) streak_d = '0;
            // Data wins unless fetch is pending and has already waited out its streak
            if (dm_req_i && (!if_req_i || (streak_q < LIMIT_C))) begin
               state_d     = GNT_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
               mem_be_d    = dm_be_i;
               if (if_req_i) streak_d = streak_q + 1'b1;
            end else if (if_req_i) begin
               state_d     = GNT_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr_i;
               mem_wdata_d = '0;
               mem_be_d    = 4'b1111;
               streak_d    = '0;
            end
         end
         GNT_IF, GNT_DM: begin
            if (mem_ack_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (if_ack) if_rdata_d = mem_rdata_i;
      if (dm_ack) dm_rdata_d = mem_rdata_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;
   assign if_ack_o    = if_ack;
   assign dm_ack_o    = dm_ack;
   // The ack cycle forwards memory data straight through; otherwise show the captured copy
   assign if_rdata_o  = if_ack ? mem_rdata_i : if_rdata_q;
   assign dm_rdata_o  = dm_ack ? mem_rdata_i : dm_rdata_q;
   assign stall_if_o  = if_req_i & ~if_ack;
   assign stall_dm_o  = dm_req_i & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration tables for STARVE_LIMIT=4 and 0, plus reset, wait-state and hold sequences.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        dm_req_i = 1'b0;
   logic        dm_we_i = 1'b0;
   logic [31:0] dm_addr_i = '0;
   logic [31:0] dm_wdata_i = '0;
   logic [3:0]  dm_be_i = '0;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;

   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
   logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_if_o, stall_dm_o;
   logic [3:0]  mem_be_o;
   logic [31:0] if_rdata0, dm_rdata0, mem_addr0, mem_wdata0;
   logic        if_ack0, dm_ack0, mem_req0, mem_we0, stall_if0, stall_dm0;
   logic [3:0]  mem_be0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_be_i(dm_be_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
      .mem_ack_i(mem_ack_i), .stall_if_o(stall_if_o), .stall_dm_o(stall_dm_o)
   );

   mem_port_arbiter #(.STARVE_LIMIT(0), .CNT_W(3)) dut0 (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata0), .if_ack_o(if_ack0),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_be_i(dm_be_i), .dm_rdata_o(dm_rdata0), .dm_ack_o(dm_ack0),
      .mem_req_o(mem_req0), .mem_we_o(mem_we0), .mem_addr_o(mem_addr0),
      .mem_wdata_o(mem_wdata0), .mem_be_o(mem_be0), .mem_rdata_i(mem_rdata_i),
      .mem_ack_i(mem_ack_i), .stall_if_o(stall_if0), .stall_dm_o(stall_dm0)
   );

   typedef struct {
      logic        sel0;
      logic        if_req;
      logic        dm_req;
      logic        mem_ack;
      logic        e_mem_req;
      logic [31:0] e_addr;
      logic        e_if_ack;
      logic        e_dm_ack;
      logic        e_stall_if;
      logic        e_stall_dm;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic s0, input logic ir, input logic dr, input logic ma,
                               input logic mr, input logic [31:0] ad, input logic ia,
                               input logic da, input logic si, input logic sd);
      vec_t v;
      v.sel0 = s0; v.if_req = ir; v.dm_req = dr; v.mem_ack = ma;
      v.e_mem_req = mr; v.e_addr = ad; v.e_if_ack = ia; v.e_dm_ack = da;
      v.e_stall_if = si; v.e_stall_dm = sd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
      rst = 0;
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      int hi_cnt, stall_cnt, ack_cnt;

      // STARVE_LIMIT=4, both requesting, zero-wait memory
      tbl.push_back(mk(0,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(0,1,1,1, 1,32'h2000, 0,1,1,0));
      tbl.push_back(mk(0,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(0,1,1,1, 1,32'h2000, 0,1,1,0));
      tbl.push_back(mk(0,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(0,1,1,1, 1,32'h2000, 0,1,1,0));
      tbl.push_back(mk(0,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(0,1,1,1, 1,32'h2000, 0,1,1,0));
      tbl.push_back(mk(0,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(0,1,1,1, 1,32'h100,  1,0,0,1));
      tbl.push_back(mk(0,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(0,1,1,1, 1,32'h2000, 0,1,1,0));
      // STARVE_LIMIT=0: fetch always wins; data only gets IDLE cycles without a fetch
      tbl.push_back(mk(1,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(1,1,1,1, 1,32'h100,  1,0,0,1));
      tbl.push_back(mk(1,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(1,1,1,1, 1,32'h100,  1,0,0,1));
      tbl.push_back(mk(1,0,1,1, 0,32'h0,    0,0,0,1));
      tbl.push_back(mk(1,1,1,1, 1,32'h2000, 0,1,1,0));
      tbl.push_back(mk(1,1,1,1, 0,32'h0,    0,0,1,1));
      tbl.push_back(mk(1,1,1,1, 1,32'h100,  1,0,0,1));

      if_addr_i = 32'h100; dm_addr_i = 32'h2000; dm_wdata_i = 32'h0; dm_be_i = 4'hF;
      do_reset();
      chk("reset_mem_req", {31'b0, mem_req_o}, 32'h0);
      chk("reset_if_rdata", if_rdata_o, 32'h0);

      for (int i = 0; i < tbl.size(); i++) begin
         if (i > 0 && tbl[i].sel0 != tbl[i-1].sel0) do_reset();
         @(negedge clk);
         if_req_i = tbl[i].if_req; dm_req_i = tbl[i].dm_req; mem_ack_i = tbl[i].mem_ack;
         #1;
         if (tbl[i].sel0) begin
            chk($sformatf("t%0d_mem_req", i), {31'b0, mem_req0}, {31'b0, tbl[i].e_mem_req});
            if (tbl[i].e_mem_req) chk($sformatf("t%0d_addr", i), mem_addr0, tbl[i].e_addr);
            chk($sformatf("t%0d_if_ack", i), {31'b0, if_ack0}, {31'b0, tbl[i].e_if_ack});
            chk($sformatf("t%0d_dm_ack", i), {31'b0, dm_ack0}, {31'b0, tbl[i].e_dm_ack});
            chk($sformatf("t%0d_stall_if", i), {31'b0, stall_if0}, {31'b0, tbl[i].e_stall_if});
            chk($sformatf("t%0d_stall_dm", i), {31'b0, stall_dm0}, {31'b0, tbl[i].e_stall_dm});
         end else begin
            chk($sformatf("t%0d_mem_req", i), {31'b0, mem_req_o}, {31'b0, tbl[i].e_mem_req});
            if (tbl[i].e_mem_req) chk($sformatf("t%0d_addr", i), mem_addr_o, tbl[i].e_addr);
            chk($sformatf("t%0d_if_ack", i), {31'b0, if_ack_o}, {31'b0, tbl[i].e_if_ack});
            chk($sformatf("t%0d_dm_ack", i), {31'b0, dm_ack_o}, {31'b0, tbl[i].e_dm_ack});
            chk($sformatf("t%0d_stall_if", i), {31'b0, stall_if_o}, {31'b0, tbl[i].e_stall_if});
            chk($sformatf("t%0d_stall_dm", i), {31'b0, stall_dm_o}, {31'b0, tbl[i].e_stall_dm});
         end
      end

      // Asynchronous reset in the middle of a data grant
      do_reset();
      @(negedge clk);
      dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h2000; dm_wdata_i = 32'h12345678; dm_be_i = 4'hF;
      mem_ack_i = 0;
      @(negedge clk); #1;
      chk("rst_pre_mem_req", {31'b0, mem_req_o}, 32'h1);
      #2 rst = 0;
      #1;
      chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we_o}, 32'h0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_mem_wdata", mem_wdata_o, 32'h0);
      chk("rst_mem_be", {28'b0, mem_be_o}, 32'h0);
      @(negedge clk);
      rst = 1; dm_req_i = 0; dm_we_i = 0; mem_ack_i = 1;
      #1;
      chk("rst_late_if_ack", {31'b0, if_ack_o}, 32'h0);
      chk("rst_late_dm_ack", {31'b0, dm_ack_o}, 32'h0);
      @(negedge clk);
      mem_ack_i = 0;
      #1;
      chk("rst_after_mem_req", {31'b0, mem_req_o}, 32'h0);

      // Fetch only with zero-wait memory: one access per two cycles
      do_reset();
      if_addr_i = 32'h100; mem_rdata_i = 32'h00500093; mem_ack_i = 1;
      hi_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if_req_i = 1;
         #1;
         if (mem_req_o) hi_cnt++;
         chk($sformatf("fo%0d_mem_req", k), {31'b0, mem_req_o}, {31'b0, k[0]});
         if (k[0]) begin
            chk($sformatf("fo%0d_addr", k), mem_addr_o, 32'h100);
            chk($sformatf("fo%0d_be", k), {28'b0, mem_be_o}, 32'hF);
            chk($sformatf("fo%0d_we", k), {31'b0, mem_we_o}, 32'h0);
            chk($sformatf("fo%0d_if_ack", k), {31'b0, if_ack_o}, 32'h1);
            chk($sformatf("fo%0d_if_rdata", k), if_rdata_o, 32'h00500093);
         end
      end
      chk("fo_req_cycles", hi_cnt, 3);

      // Store with three wait states
      do_reset();
      @(negedge clk);
      dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h2000; dm_wdata_i = 32'hDEADBEEF; dm_be_i = 4'b0011;
      stall_cnt = 0; ack_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         mem_ack_i = (k == 4);
         if (k == 5) dm_req_i = 0;
         #1;
         if (stall_dm_o) stall_cnt++;
         if (dm_ack_o) ack_cnt++;
         if (k >= 1 && k <= 4) begin
            chk($sformatf("st%0d_mem_req", k), {31'b0, mem_req_o}, 32'h1);
            chk($sformatf("st%0d_we", k), {31'b0, mem_we_o}, 32'h1);
            chk($sformatf("st%0d_addr", k), mem_addr_o, 32'h2000);
            chk($sformatf("st%0d_wdata", k), mem_wdata_o, 32'hDEADBEEF);
            chk($sformatf("st%0d_be", k), {28'b0, mem_be_o}, 32'h3);
         end
      end
      chk("st_stall_cycles", stall_cnt, 4);
      chk("st_ack_count", ack_cnt, 1);
      chk("st_idle_mem_req", {31'b0, mem_req_o}, 32'h0);
      chk("st_idle_addr_kept", mem_addr_o, 32'h2000);

      // Read-data hold across later memory traffic and a data ack
      do_reset();
      @(negedge clk);
      if_req_i = 1; if_addr_i = 32'h104; dm_we_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hAAAA0001;
      @(negedge clk); #1;
      chk("hold_if_ack", {31'b0, if_ack_o}, 32'h1);
      chk("hold_if_rdata0", if_rdata_o, 32'hAAAA0001);
      @(negedge clk);
      if_req_i = 0; mem_rdata_i = 32'h55550002; dm_req_i = 1; dm_addr_i = 32'h3000;
      #1;
      chk("hold_if_rdata1", if_rdata_o, 32'hAAAA0001);
      @(negedge clk);
      mem_rdata_i = 32'hCCCC0003;
      #1;
      chk("hold_dm_ack", {31'b0, dm_ack_o}, 32'h1);
      chk("hold_dm_rdata", dm_rdata_o, 32'hCCCC0003);
      chk("hold_if_rdata2", if_rdata_o, 32'hAAAA0001);
      @(negedge clk);
      dm_req_i = 0; mem_rdata_i = 32'h77770004;
      #1;
      chk("hold_dm_rdata_kept", dm_rdata_o, 32'hCCCC0003);
      chk("hold_if_rdata3", if_rdata_o, 32'hAAAA0001);
      @(negedge clk);
      if_req_i = 1; mem_rdata_i = 32'h99990005;
      @(negedge clk); #1;
      chk("hold_if_ack2", {31'b0, if_ack_o}, 32'h1);
      chk("hold_if_rdata4", if_rdata_o, 32'h99990005);

      // Requester drops its request while granted: access still completes with an ack
      @(negedge clk);
      if_req_i = 0; dm_req_i = 1; mem_ack_i = 0;
      @(negedge clk);
      dm_req_i = 0; mem_ack_i = 1;
      #1;
      chk("drop_dm_ack", {31'b0, dm_ack_o}, 32'h1);

      @(negedge clk);
      mem_ack_i = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
